// File: rtl/ddr_axi_pkg.sv
// Shared AXI write-channel constants and the burst writer FSM state type.
package ddr_axi_pkg;

  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_DATA_W = 32;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } wr_state_e;

endpackage

// File: rtl/ddr_wr_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module ddr_wr_fifo #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign o_full    = (r_count == DEPTH_C);
  assign w_pop_ok  = i_pop && (r_count != '0);
  // A push into a full FIFO is accepted only when a pop frees the slot this cycle.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_head    = r_mem[r_rptr];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      if (w_push_ok && !w_pop_ok)      r_count <= r_count + 1'b1;
      else if (!w_push_ok && w_pop_ok) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/ddr_stream_burst_writer.sv
// Stream-to-DDR ring writer: buffers a word stream and drains it as fixed INCR bursts.
// Optional partial-burst flush input enabled by defining DDR_WR_FLUSH_EN.
module ddr_stream_burst_writer
  import ddr_axi_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
  parameter logic [31:0] ADDR_SPAN  = 32'h0010_0000,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter logic [3:0]  WR_ID      = 4'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
`ifdef DDR_WR_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic [AXI_DATA_W-1:0] IN_DATA,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [AXI_ID_W-1:0]   WR_ADDR_ID,
  output logic [31:0]           WR_ADDR,
  output logic [7:0]            WR_ADDR_LEN,
  output logic [1:0]            WR_ADDR_BURST,
  output logic                  WR_ADDR_VALID,
  input  logic                  WR_ADDR_READY,
  output logic [AXI_DATA_W-1:0] WR_DATA,
  output logic [3:0]            WR_STRB,
  output logic                  WR_DATA_LAST,
  output logic                  WR_DATA_VALID,
  input  logic                  WR_DATA_READY,
  input  logic [AXI_ID_W-1:0]   WR_BACK_ID,
  input  logic [1:0]            WR_BACK_RESP,
  input  logic                  WR_BACK_VALID,
  output logic                  WR_BACK_READY,
  output logic                  busy,
  output logic                  err,
  output logic [31:0]           burst_cnt
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] BL_C   = CW'(BURST_LEN);
  localparam logic [8:0]    BL9    = 9'(BURST_LEN);
  localparam logic [31:0]   BL32   = 32'(BURST_LEN);
  localparam logic [31:0]   RING_END = ADDR_BASE + ADDR_SPAN;

  wr_state_e              r_state;
  wr_state_e              w_next;
  logic [8:0]             r_len;
  logic [8:0]             r_beat;
  logic [31:0]            r_cur_addr;
  logic                   r_err;
  logic [31:0]            r_burst_cnt;
  logic                   r_started;
  logic                   w_start;
  logic [8:0]             w_start_len;
  logic [AXI_DATA_W-1:0]  w_head;
  logic [CW-1:0]          w_count;
  logic                   w_full;
  logic                   w_push;
  logic                   w_pop;
  logic [31:0]            w_addr_inc;
  logic                   w_unused_id;

  assign w_unused_id = &{1'b0, WR_BACK_ID};

  assign w_push = IN_VALID && IN_READY;
  assign w_pop  = (r_state == ST_DATA) && WR_DATA_READY;

  ddr_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (AXI_DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (IN_DATA),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full)
  );

  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_start_len = BL9;
    case (r_state)
      ST_IDLE: begin
        if (enable && (w_count >= BL_C)) begin
          w_next  = ST_ADDR;
          w_start = 1'b1;
        end
`ifdef DDR_WR_FLUSH_EN
        else if (enable && flush && (w_count != '0)) begin
          w_next      = ST_ADDR;
          w_start     = 1'b1;
          w_start_len = 9'(w_count);
        end
`endif
      end
      ST_ADDR: if (WR_ADDR_READY) w_next = ST_DATA;
      ST_DATA: if (WR_DATA_READY && (r_beat == 9'd1)) w_next = ST_RESP;
      ST_RESP: if (WR_BACK_VALID) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Partial bursts still advance by a full BURST_LEN so bursts never straddle the ring end.
  assign w_addr_inc = (r_cur_addr + BL32 == RING_END) ? ADDR_BASE : r_cur_addr + BL32;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_len       <= BL9;
      r_beat      <= '0;
      r_cur_addr  <= ADDR_BASE;
      r_err       <= 1'b0;
      r_burst_cnt <= '0;
      r_started   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_started <= 1'b1;
      if (w_start) begin
        r_len  <= w_start_len;
        r_beat <= w_start_len;
      end else if (w_pop) begin
        r_beat <= r_beat - 9'd1;
      end
      if ((r_state == ST_RESP) && WR_BACK_VALID) begin
        if (WR_BACK_RESP != AXI_RESP_OKAY) r_err <= 1'b1;
        r_burst_cnt <= r_burst_cnt + 32'd1;
        r_cur_addr  <= w_addr_inc;
      end
    end
  end

  assign IN_READY      = r_started && !w_full;
  assign WR_ADDR_ID    = WR_ID;
  assign WR_ADDR       = r_cur_addr;
  assign WR_ADDR_LEN   = 8'(r_len - 9'd1);
  assign WR_ADDR_BURST = AXI_BURST_INCR;
  assign WR_ADDR_VALID = (r_state == ST_ADDR);
  assign WR_DATA       = (r_state == ST_DATA) ? w_head : '0;
  assign WR_STRB       = 4'hF;
  assign WR_DATA_LAST  = (r_state == ST_DATA) && (r_beat == 9'd1);
  assign WR_DATA_VALID = (r_state == ST_DATA);
  assign WR_BACK_READY = (r_state == ST_RESP);
  assign busy          = (r_state != ST_IDLE);
  assign err           = r_err;
  assign burst_cnt     = r_burst_cnt;

endmodule

// File: tb/tb_ddr_stream_burst_writer.sv
// Bench for ddr_stream_burst_writer: ring of 32 words, 16-beat bursts, 64-word FIFO.
// Flush sequence is compiled in when DDR_WR_FLUSH_EN is defined.
module tb_ddr_stream_burst_writer;
  import ddr_axi_pkg::*;

  localparam int BL    = 16;
  localparam int SPAN  = 32;
  localparam int DEPTH = 64;

  logic        clk, rst_n, enable;
`ifdef DDR_WR_FLUSH_EN
  logic        flush;
`endif
  logic [31:0] IN_DATA;
  logic        IN_VALID, IN_READY;
  logic [3:0]  WR_ADDR_ID;
  logic [31:0] WR_ADDR;
  logic [7:0]  WR_ADDR_LEN;
  logic [1:0]  WR_ADDR_BURST;
  logic        WR_ADDR_VALID, WR_ADDR_READY;
  logic [31:0] WR_DATA;
  logic [3:0]  WR_STRB;
  logic        WR_DATA_LAST, WR_DATA_VALID, WR_DATA_READY;
  logic [3:0]  WR_BACK_ID;
  logic [1:0]  WR_BACK_RESP;
  logic        WR_BACK_VALID, WR_BACK_READY;
  logic        busy, err;
  logic [31:0] burst_cnt;

  ddr_stream_burst_writer #(
    .ADDR_BASE  (32'h0),
    .ADDR_SPAN  (32'd32),
    .BURST_LEN  (BL),
    .FIFO_DEPTH (DEPTH),
    .WR_ID      (4'h5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
`ifdef DDR_WR_FLUSH_EN
    .flush(flush),
`endif
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .WR_ADDR_ID(WR_ADDR_ID), .WR_ADDR(WR_ADDR), .WR_ADDR_LEN(WR_ADDR_LEN),
    .WR_ADDR_BURST(WR_ADDR_BURST), .WR_ADDR_VALID(WR_ADDR_VALID), .WR_ADDR_READY(WR_ADDR_READY),
    .WR_DATA(WR_DATA), .WR_STRB(WR_STRB), .WR_DATA_LAST(WR_DATA_LAST),
    .WR_DATA_VALID(WR_DATA_VALID), .WR_DATA_READY(WR_DATA_READY),
    .WR_BACK_ID(WR_BACK_ID), .WR_BACK_RESP(WR_BACK_RESP),
    .WR_BACK_VALID(WR_BACK_VALID), .WR_BACK_READY(WR_BACK_READY),
    .busy(busy), .err(err), .burst_cnt(burst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: words in flight, slave memory and burst bookkeeping.
  int          checks = 0;
  int          fails  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem [SPAN];
  int          issued, cur_len, cur_base, beat, pend_b, exp_len_next;
  bit          in_burst;
  int          aw_mode, w_mode, b_mode, in_mode;  // 0 always, 1 toggle, 2 random, 3 never
  logic [1:0]  resp_code;
  int          words_left;
  logic [31:0] word_ctr;
  int          cyc;
  bit          aw_hold, w_hold;
  logic [31:0] aw_prev_addr, w_prev_data;
  logic        w_prev_last;

  typedef struct {
    int         words;
    int         mode;
    logic [1:0] resp;
    int         exp_bc;
    logic       exp_err;
    int         mem_base;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit pick(input int m);
    case (m)
      0: return 1'b1;
      1: return (cyc % 2) == 0;
      2: return 1'($urandom_range(0, 1));
      default: return 1'b0;
    endcase
  endfunction

  task automatic cycle();
    logic [31:0] w;
    @(negedge clk);
    cyc++;
    if (aw_hold) begin
      check("aw_valid_held", 64'(WR_ADDR_VALID), 64'd1);
      check("aw_addr_stable", 64'(WR_ADDR), 64'(aw_prev_addr));
    end
    if (w_hold) begin
      check("w_valid_held", 64'(WR_DATA_VALID), 64'd1);
      check("w_data_stable", 64'(WR_DATA), 64'(w_prev_data));
      check("w_last_stable", 64'(WR_DATA_LAST), 64'(w_prev_last));
    end
    WR_ADDR_READY = pick(aw_mode);
    WR_DATA_READY = pick(w_mode);
    WR_BACK_VALID = (pend_b > 0) && pick(b_mode);
    WR_BACK_RESP  = resp_code;

    if (WR_ADDR_VALID && WR_ADDR_READY) begin
      check("aw_addr", 64'(WR_ADDR), 64'((issued * BL) % SPAN));
      check("aw_len", 64'(WR_ADDR_LEN), 64'(exp_len_next - 1));
      check("aw_id_burst", 64'({WR_ADDR_ID, WR_ADDR_BURST}), 64'({4'h5, 2'b01}));
      cur_base = (issued * BL) % SPAN;
      issued++;
      cur_len = exp_len_next;
      exp_len_next = BL;
      beat = 0;
      in_burst = 1'b1;
    end
    aw_hold = WR_ADDR_VALID && !WR_ADDR_READY;
    aw_prev_addr = WR_ADDR;

    if (WR_DATA_VALID && WR_DATA_READY) begin
      if (!in_burst || exp_q.size() == 0) begin
        check("w_unexpected_beat", 64'd1, 64'd0);
      end else begin
        w = exp_q.pop_front();
        check("w_data", 64'(WR_DATA), 64'(w));
        check("w_last", 64'(WR_DATA_LAST), 64'(beat == cur_len - 1));
        check("w_strb", 64'(WR_STRB), 64'hF);
        mem[(cur_base + beat) % SPAN] = WR_DATA;
        beat++;
        if (beat == cur_len) begin
          in_burst = 1'b0;
          pend_b++;
        end
      end
    end
    w_hold = WR_DATA_VALID && !WR_DATA_READY;
    w_prev_data = WR_DATA;
    w_prev_last = WR_DATA_LAST;

    if (WR_BACK_VALID && WR_BACK_READY) pend_b--;

    IN_VALID = (words_left > 0) && pick(in_mode);
    IN_DATA  = word_ctr;
    if (IN_VALID && IN_READY) begin
      exp_q.push_back(word_ctr);
      word_ctr++;
      words_left--;
    end
  endtask

  task automatic settle(input string name);
    int n;
    n = 0;
    while (!(words_left == 0 && !busy && pend_b == 0 && exp_q.size() < BL) && n < 3000) begin
      cycle();
      n++;
    end
    check({name, "_settled"}, 64'(n < 3000), 64'd1);
    repeat (3) cycle();
    check({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 64'(IN_READY), 64'd0);
    check({tag, "_valids"}, 64'({WR_ADDR_VALID, WR_DATA_VALID, WR_BACK_READY, WR_DATA_LAST}), 64'd0);
    check({tag, "_addr"}, 64'(WR_ADDR), 64'd0);
    check({tag, "_len"}, 64'(WR_ADDR_LEN), 64'd15);
    check({tag, "_wdata"}, 64'(WR_DATA), 64'd0);
    check({tag, "_status"}, 64'({busy, err}), 64'd0);
    check({tag, "_burst_cnt"}, 64'(burst_cnt), 64'd0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    issued = 0; pend_b = 0; beat = 0; cur_len = BL; cur_base = 0;
    in_burst = 1'b0; aw_hold = 1'b0; w_hold = 1'b0;
    exp_len_next = BL; words_left = 0;
    IN_VALID = 1'b0; WR_ADDR_READY = 1'b0; WR_DATA_READY = 1'b0; WR_BACK_VALID = 1'b0;
  endtask

  initial begin
    int n;
    tbl[0] = '{32, 0, 2'b00, 2,  1'b0, 0};
    tbl[1] = '{32, 1, 2'b00, 4,  1'b0, 32};
    tbl[2] = '{16, 2, 2'b10, 5,  1'b1, -1};
    tbl[3] = '{16, 0, 2'b00, 6,  1'b1, -1};
    tbl[4] = '{24, 2, 2'b00, 7,  1'b1, -1};
    tbl[5] = '{40, 2, 2'b00, 10, 1'b1, -1};

    rst_n = 1'b0; enable = 1'b1;
`ifdef DDR_WR_FLUSH_EN
    flush = 1'b0;
`endif
    IN_DATA = '0; WR_BACK_ID = 4'h3; WR_BACK_RESP = 2'b00;
    aw_mode = 0; w_mode = 0; b_mode = 0; in_mode = 0;
    resp_code = 2'b00; word_ctr = '0; cyc = 0;
    model_reset();

    #22;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("in_ready_before_clk", 64'(IN_READY), 64'd0);
    cycle();
    check("in_ready_after_rst", 64'(IN_READY), 64'd1);

    for (int i = 0; i < 6; i++) begin
      w_mode    = tbl[i].mode;
      aw_mode   = (tbl[i].mode == 1) ? 0 : tbl[i].mode;
      b_mode    = aw_mode;
      in_mode   = aw_mode;
      resp_code = tbl[i].resp;
      words_left = tbl[i].words;
      settle($sformatf("vec%0d", i));
      check($sformatf("vec%0d_burst_cnt", i), 64'(burst_cnt), 64'(tbl[i].exp_bc));
      check($sformatf("vec%0d_err", i), 64'(err), 64'(tbl[i].exp_err));
      if (tbl[i].mem_base >= 0)
        for (int a = 0; a < SPAN; a++)
          check($sformatf("vec%0d_mem%0d", i, a), 64'(mem[a]), 64'(tbl[i].mem_base + a));
    end

    // Address channel stalled: FIFO fills to DEPTH, address request holds.
    aw_mode = 3; w_mode = 0; b_mode = 0; in_mode = 0; resp_code = 2'b00;
    words_left = 66;
    repeat (100) cycle();
    check("bp_accepted", 64'(exp_q.size()), 64'(DEPTH));
    check("bp_in_ready", 64'(IN_READY), 64'd0);
    check("bp_aw_valid", 64'(WR_ADDR_VALID), 64'd1);
    check("bp_aw_addr", 64'(WR_ADDR), 64'd0);
    aw_mode = 0;
    settle("bp_drain");
    check("bp_burst_cnt", 64'(burst_cnt), 64'd14);
    words_left = 14;
    settle("bp_tail");
    check("bp_tail_burst_cnt", 64'(burst_cnt), 64'd15);

    // enable low blocks new bursts even with a full burst buffered.
    enable = 1'b0;
    words_left = 16;
    repeat (30) cycle();
    check("dis_busy", 64'(busy), 64'd0);
    check("dis_aw_valid", 64'(WR_ADDR_VALID), 64'd0);
    check("dis_burst_cnt", 64'(burst_cnt), 64'd15);
    enable = 1'b1;
    settle("en");
    check("en_burst_cnt", 64'(burst_cnt), 64'd16);
    check("en_err_sticky", 64'(err), 64'd1);

    // Asynchronous reset in the middle of a data phase.
    w_mode = 3;
    words_left = 16;
    n = 0;
    while (!WR_DATA_VALID && n < 200) begin
      cycle();
      n++;
    end
    check("mid_reached_data", 64'(WR_DATA_VALID), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    w_mode = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

`ifdef DDR_WR_FLUSH_EN
    words_left = 5;
    settle("fl_fill");
    check("fl_no_burst", 64'(burst_cnt), 64'd0);
    exp_len_next = 5;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    settle("fl_burst");
    check("fl_burst_cnt", 64'(burst_cnt), 64'd1);
`endif
    words_left = 16;
    settle("post_rst");
`ifdef DDR_WR_FLUSH_EN
    check("post_rst_burst_cnt", 64'(burst_cnt), 64'd2);
`else
    check("post_rst_burst_cnt", 64'(burst_cnt), 64'd1);
`endif
    check("post_rst_err", 64'(err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
